// File: rtl/img_coder_pkg.sv
// Shared image-coder types: subband kinds, reader FSM states, geometry helpers.
// No logic; imported by the subband reader and its address generator.
package img_coder_pkg;

  typedef enum logic [1:0] {
    SB_LL = 2'd0,
    SB_HL = 2'd1,
    SB_LH = 2'd2,
    SB_HH = 2'd3
  } sb_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } rd_state_e;

  function automatic int nsb_f(input int levels);
    return 3 * levels + 1;
  endfunction

  function automatic int sb_w_f(input int levels);
    return $clog2(3 * levels + 1);
  endfunction

  function automatic int addr_w_f(input int img_log2);
    return 2 * img_log2;
  endfunction

endpackage

// File: rtl/subband_addr_gen.sv
// Walks the Mallat layout subband by subband (coarsest first), raster inside each.
// Latency: outputs describe the current coefficient combinationally; step advances one.
// Backpressure: none internally, the caller only pulses step when it consumes an address.
module subband_addr_gen
  import img_coder_pkg::*;
#(
  parameter int IMG_LOG2 = 6,
  parameter int LEVELS   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  output logic [addr_w_f(IMG_LOG2)-1:0] address,
  output logic [sb_w_f(LEVELS)-1:0]     subband,
  output logic                          sb_last,
  output logic                          frame_last
);

  localparam int NSB  = nsb_f(LEVELS);
  localparam int SB_W = sb_w_f(LEVELS);
  localparam int SH_W = $clog2(IMG_LOG2 + 1);
  localparam logic [SH_W-1:0]     SH_TOP = SH_W'(IMG_LOG2 - LEVELS);
  localparam logic [IMG_LOG2-1:0] ONE    = IMG_LOG2'(1);
  localparam logic [SB_W-1:0]     SB_END = SB_W'(NSB - 1);

  sb_kind_e            kind;
  logic [SH_W-1:0]     sh;
  logic [SB_W-1:0]     sb;
  logic [IMG_LOG2-1:0] r, c;
  logic [IMG_LOG2-1:0] side, side_m1, row, col;

  // sh is log2 of the current subband side; it grows by one each time HH hands over to the next finer level.
  always_comb begin
    side    = ONE << sh;
    side_m1 = side - ONE;
    row     = r;
    col     = c;
    if (kind == SB_LH || kind == SB_HH) row = r + side;
    if (kind == SB_HL || kind == SB_HH) col = c + side;
  end

  assign address    = {row, col};
  assign subband    = sb;
  assign sb_last    = (r == side_m1) && (c == side_m1);
  assign frame_last = sb_last && (sb == SB_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      kind <= SB_LL;
      sh   <= SH_TOP;
      sb   <= '0;
      r    <= '0;
      c    <= '0;
    end else if (step) begin
      if (c != side_m1) begin
        c <= c + ONE;
      end else begin
        c <= '0;
        if (r != side_m1) begin
          r <= r + ONE;
        end else begin
          r <= '0;
          if (frame_last) begin
            kind <= SB_LL;
            sh   <= SH_TOP;
            sb   <= '0;
          end else begin
            sb <= sb + SB_W'(1);
            case (kind)
              SB_LL:   kind <= SB_HL;
              SB_HL:   kind <= SB_LH;
              SB_LH:   kind <= SB_HH;
              default: begin
                kind <= SB_HL;
                sh   <= sh + SH_W'(1);
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: rtl/ram_subband_reader.sv
// Reads a finished DWT frame from coefficient RAM and hands it out as lane groups per subband.
// Latency: group presented RD_LAT+1 cycles after its last read issues; one read per cycle.
// Backpressure: group held stable while bitplane_code_ready is low; no reads issue meanwhile.
module ram_subband_reader
  import img_coder_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int IMG_LOG2 = 6,
  parameter int LEVELS   = 3,
  parameter int LANES    = 9,
  parameter int RD_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wavelet_end,
  output logic                          ram_rd_en,
  output logic [addr_w_f(IMG_LOG2)-1:0] ram_read_address,
  input  logic [DATA_W-1:0]             ram_data_input,
  output logic [LANES*DATA_W-1:0]       lane_data,
  output logic [$clog2(LANES+1)-1:0]    lane_count,
  output logic [sb_w_f(LEVELS)-1:0]     subband,
  output logic                          group_valid,
  input  logic                          bitplane_code_ready,
  output logic                          sb_last,
  output logic                          frame_last,
  output logic                          busy
);

  localparam int ADDR_W = addr_w_f(IMG_LOG2);
  localparam int SB_W   = sb_w_f(LEVELS);
  localparam int LC_W   = $clog2(LANES + 1);
  localparam int LI_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LC_W-1:0] LC_ONE  = LC_W'(1);
  localparam logic [LC_W-1:0] LC_FULL = LC_W'(LANES);

  rd_state_e         state;
  logic [DATA_W-1:0] lanes_q [LANES];
  logic [LC_W-1:0]   issue_cnt, ret_cnt;
  logic [LI_W-1:0]   rd_lane;
  logic              tag_vld  [RD_LAT];
  logic [LI_W-1:0]   tag_lane [RD_LAT];

  logic [ADDR_W-1:0] gen_addr;
  logic [SB_W-1:0]   gen_sb;
  logic              gen_sb_last, gen_frame_last;
  logic              accept, start_grp, issue_more, ret_hit, ret_done, gen_step;

  // sb_last tracks the read currently on the bus, so it also closes a group at the subband edge.
  assign accept     = (state == ST_PRESENT) && bitplane_code_ready;
  assign start_grp  = ((state == ST_IDLE) && wavelet_end) || (accept && !frame_last);
  assign issue_more = (state == ST_ISSUE) && (issue_cnt != LC_FULL) && !sb_last;
  assign gen_step   = start_grp || issue_more;
  assign ret_hit    = tag_vld[RD_LAT-1];
  assign ret_done   = ret_hit && ((ret_cnt + LC_ONE) == issue_cnt);
  assign lane_count = issue_cnt;

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) lane_data[i*DATA_W +: DATA_W] = lanes_q[i];
  end

  subband_addr_gen #(
    .IMG_LOG2 (IMG_LOG2),
    .LEVELS   (LEVELS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .step       (gen_step),
    .address    (gen_addr),
    .subband    (gen_sb),
    .sb_last    (gen_sb_last),
    .frame_last (gen_frame_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      ram_rd_en        <= 1'b0;
      ram_read_address <= '0;
      group_valid      <= 1'b0;
      subband          <= '0;
      sb_last          <= 1'b0;
      frame_last       <= 1'b0;
      busy             <= 1'b0;
      issue_cnt        <= '0;
      ret_cnt          <= '0;
      rd_lane          <= '0;
      for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_lane[i] <= '0;
      end
    end else begin
      // Each read carries its lane index down a pipe as deep as the RAM latency.
      tag_vld[0]  <= ram_rd_en;
      tag_lane[0] <= rd_lane;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_lane[i] <= tag_lane[i-1];
      end

      if (ret_hit) begin
        lanes_q[tag_lane[RD_LAT-1]] <= ram_data_input;
        ret_cnt <= ret_cnt + LC_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (wavelet_end) busy <= 1'b1;
        end
        ST_ISSUE: begin
          if (!issue_more) begin
            ram_rd_en <= 1'b0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ret_done) begin
            group_valid <= 1'b1;
            state       <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (accept) begin
            group_valid <= 1'b0;
            if (frame_last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (start_grp) begin
        state            <= ST_ISSUE;
        ram_rd_en        <= 1'b1;
        ram_read_address <= gen_addr;
        subband          <= gen_sb;
        sb_last          <= gen_sb_last;
        frame_last       <= gen_frame_last;
        issue_cnt        <= LC_ONE;
        ret_cnt          <= '0;
        rd_lane          <= '0;
        for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
      end else if (issue_more) begin
        ram_rd_en        <= 1'b1;
        ram_read_address <= gen_addr;
        sb_last          <= gen_sb_last;
        frame_last       <= gen_frame_last;
        issue_cnt        <= issue_cnt + LC_ONE;
        rd_lane          <= LI_W'(issue_cnt);
      end
    end
  end

endmodule

// File: tb/tb_ram_subband_reader.sv
// Scoreboard bench: 8x8 image, one level; instance A has 4 lanes / 1-cycle RAM, B 3 lanes / 3-cycle RAM.
module tb_ram_subband_reader;

  typedef struct packed {
    logic [63:0] dat;
    logic [2:0]  cnt;
    logic [1:0]  sb;
    logic        sbl;
    logic        fl;
  } grp_t;

  logic clk, rst;
  logic we_a, rd_a, gv_a, rdy_a, sbl_a, fl_a, busy_a;
  logic [5:0] addr_a;
  logic [15:0] rdata_a;
  logic [63:0] ld_a;
  logic [2:0] lc_a;
  logic [1:0] sb_a;
  logic we_b, rd_b, gv_b, rdy_b, sbl_b, fl_b, busy_b;
  logic [5:0] addr_b;
  logic [15:0] rdata_b, p1_b, p2_b, p3_b;
  logic [47:0] ld_b;
  logic [1:0] lc_b;
  logic [1:0] sb_b;

  int tests = 0;
  int failed = 0;
  int fl_cnt_a = 0;
  int fl_cnt_b = 0;
  int viol = 0;
  grp_t exp_a[$];
  grp_t exp_b[$];
  grp_t act_a, act_b, e_a, e_b;

  ram_subband_reader #(.DATA_W(16), .IMG_LOG2(3), .LEVELS(1), .LANES(4), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .wavelet_end(we_a), .ram_rd_en(rd_a), .ram_read_address(addr_a),
    .ram_data_input(rdata_a), .lane_data(ld_a), .lane_count(lc_a), .subband(sb_a),
    .group_valid(gv_a), .bitplane_code_ready(rdy_a), .sb_last(sbl_a), .frame_last(fl_a), .busy(busy_a)
  );

  ram_subband_reader #(.DATA_W(16), .IMG_LOG2(3), .LEVELS(1), .LANES(3), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .wavelet_end(we_b), .ram_rd_en(rd_b), .ram_read_address(addr_b),
    .ram_data_input(rdata_b), .lane_data(ld_b), .lane_count(lc_b), .subband(sb_b),
    .group_valid(gv_b), .bitplane_code_ready(rdy_b), .sb_last(sbl_b), .frame_last(fl_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: A returns 0x1000|addr one cycle later, B returns addr three cycles later; junk otherwise.
  always @(posedge clk) begin
    rdata_a <= rd_a ? (16'h1000 | {10'd0, addr_a}) : 16'hDEAD;
    p1_b    <= rd_b ? {10'd0, addr_b} : 16'hDEAD;
    p2_b    <= p1_b;
    p3_b    <= p2_b;
  end
  assign rdata_b = p3_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Subband origins for an 8x8 image with one level: side 4, LL/HL/LH/HH.
  task automatic push_frame(input bit to_b);
    int org_r[4];
    int org_c[4];
    int lanes, cnt, p, addr;
    logic [63:0] d;
    grp_t e;
    org_r = '{0, 0, 4, 4};
    org_c = '{0, 4, 0, 4};
    lanes = to_b ? 3 : 4;
    for (int sb = 0; sb < 4; sb++) begin
      for (int k = 0; k < 16; k += lanes) begin
        d = '0;
        cnt = (16 - k < lanes) ? 16 - k : lanes;
        for (int j = 0; j < cnt; j++) begin
          p = k + j;
          addr = (org_r[sb] + p / 4) * 8 + org_c[sb] + p % 4;
          d[j*16 +: 16] = to_b ? 16'(addr) : 16'(addr + 'h1000);
        end
        e.dat = d;
        e.cnt = 3'(cnt);
        e.sb  = 2'(sb);
        e.sbl = (k + lanes >= 16);
        e.fl  = e.sbl && (sb == 3);
        if (to_b) exp_b.push_back(e);
        else exp_a.push_back(e);
      end
    end
  endtask

  task automatic pulse_we(input bit to_b);
    @(posedge clk); #1;
    if (to_b) we_b = 1'b1; else we_a = 1'b1;
    @(posedge clk); #1;
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic wait_idle(input bit to_b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((to_b ? busy_b : busy_a) && n < 1000);
    check(name, to_b ? busy_b : busy_a, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && gv_a && rdy_a) begin
      check("a_group_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) begin
        act_a = {ld_a, lc_a, sb_a, sbl_a, fl_a};
        e_a = exp_a.pop_front();
        check("a_group", act_a, e_a);
      end
      if (fl_a) fl_cnt_a++;
    end
    if (!rst && gv_b && rdy_b) begin
      check("b_group_expected", exp_b.size() != 0, 1);
      if (exp_b.size() != 0) begin
        act_b = {16'h0, ld_b, 1'b0, lc_b, sb_b, sbl_b, fl_b};
        e_b = exp_b.pop_front();
        check("b_group", act_b, e_b);
      end
      if (fl_b) fl_cnt_b++;
    end
    if (!rst && ((rd_a && gv_a) || (rd_b && gv_b))) viol++;
  end

  initial begin
    int n;
    int fl0;
    int unstable, rdbad;
    logic [71:0] snap;
    rst = 1'b1;
    we_a = 1'b0;
    we_b = 1'b0;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_a", {rd_a, addr_a, ld_a, lc_a, sb_a, gv_a, sbl_a, fl_a, busy_a}, 0);
    check("reset_b", {rd_b, addr_b, ld_b, lc_b, sb_b, gv_b, sbl_b, fl_b, busy_b}, 0);

    // Full frame, ready tied high.
    push_frame(0);
    pulse_we(0);
    check("a_busy_after_we", busy_a, 1);
    wait_idle(0, "a_frame1_idle");
    check("a_frame1_drained", exp_a.size(), 0);
    check("a_frame1_last_count", fl_cnt_a, 1);

    // Three lanes with a three-cycle RAM.
    push_frame(1);
    pulse_we(1);
    check("b_busy_after_we", busy_b, 1);
    wait_idle(1, "b_frame_idle");
    check("b_frame_drained", exp_b.size(), 0);
    check("b_frame_last_count", fl_cnt_b, 1);

    // Consumer paces every group; group 2 is held off for 10 cycles.
    rdy_a = 1'b0;
    push_frame(0);
    pulse_we(0);
    for (int g = 0; g < 16; g++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!gv_a && n < 100);
      check($sformatf("stall_grp%0d_valid", g), gv_a, 1);
      if (g == 2) begin
        snap = {ld_a, lc_a, sb_a, sbl_a, fl_a, gv_a};
        unstable = 0;
        rdbad = 0;
        repeat (10) begin
          @(negedge clk);
          if ({ld_a, lc_a, sb_a, sbl_a, fl_a, gv_a} !== snap) unstable++;
          if (rd_a) rdbad++;
        end
        check("stall_outputs_stable", unstable, 0);
        check("stall_no_read", rdbad, 0);
      end
      @(posedge clk); #1 rdy_a = 1'b1;
      @(posedge clk); #1 rdy_a = 1'b0;
    end
    rdy_a = 1'b1;
    wait_idle(0, "stall_frame_idle");
    check("stall_frame_drained", exp_a.size(), 0);
    check("stall_frame_last_count", fl_cnt_a, 2);

    // Reset while the second group is draining, then restart.
    push_frame(0);
    pulse_we(0);
    n = 0;
    while (exp_a.size() > 15 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_grp0_taken", exp_a.size(), 15);
    n = 0;
    while (!rd_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    while (rd_a && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_in_drain_no_valid", {rd_a, gv_a}, 0);
    rst = 1'b1;
    exp_a.delete();
    @(posedge clk); #1 rst = 1'b0;
    check("mid_rst_outputs", {rd_a, addr_a, ld_a, lc_a, sb_a, gv_a, sbl_a, fl_a, busy_a}, 0);
    repeat (4) @(posedge clk);
    check("mid_rst_stays_idle", {rd_a, gv_a, busy_a}, 0);
    push_frame(0);
    pulse_we(0);
    wait_idle(0, "restart_idle");
    check("restart_drained", exp_a.size(), 0);
    check("restart_last_count", fl_cnt_a, 3);

    // Extra wavelet_end pulses while busy must not start another frame.
    fl0 = fl_cnt_a;
    push_frame(0);
    pulse_we(0);
    repeat (6) @(posedge clk);
    pulse_we(0);
    repeat (30) @(posedge clk);
    pulse_we(0);
    wait_idle(0, "ignored_we_idle");
    repeat (40) @(negedge clk);
    check("ignored_we_no_restart", {busy_a, gv_a, rd_a}, 0);
    check("ignored_we_one_last", fl_cnt_a - fl0, 1);
    check("ignored_we_drained", exp_a.size(), 0);

    check("rd_while_valid", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
